// File: rtl/frame_rx_pkg.sv
// Shared definitions for the serial frame receiver.
// Holds the state encoding and a width helper used by the RTL.
package frame_rx_pkg;

    // One bit covers both states, so every encoding is legal.
    typedef enum logic {
        ST_HUNT    = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_t;

    // $clog2 with a floor of one bit, so small counts still get a usable width.
    function automatic int clog2Min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pattern_matcher.sv
// Header hunter: keeps the last PATTERN_W-1 bits and compares them,
// plus the incoming bit, against PATTERN.
// Ports: clk, rst (async, high), en (shift strobe), clr (sync clear),
//        bit_in (serial bit), match (combinational header hit).
module pattern_matcher
    import frame_rx_pkg::*;
#(
    parameter int                   PATTERN_W = 5,
    parameter logic [PATTERN_W-1:0] PATTERN   = 5'b11010
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic bit_in,
    output logic match
);

    if (PATTERN_W == 1) begin : gSingle
        // No history needed: the header is the current bit alone.
        assign match = (bit_in == PATTERN[0]);
    end else begin : gMulti
        localparam int HW = PATTERN_W - 1;
        localparam int FW = clog2Min1(PATTERN_W);
        localparam logic [FW-1:0] FILL_FULL = FW'(HW);

        logic [HW-1:0]        hist;
        logic [FW-1:0]        fill;
        logic [PATTERN_W-1:0] window;

        assign window = {hist, bit_in};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hist <= '0;
                fill <= '0;
            end else if (clr) begin
                hist <= '0;
                fill <= '0;
            end else if (en) begin
                hist <= window[HW-1:0];
                if (fill != FILL_FULL) begin
                    fill <= fill + 1'b1;
                end
            end
        end

        // Fill gate stops the cleared history from faking leading zeros.
        assign match = (window == PATTERN) && (fill == FILL_FULL);
    end

endmodule

// File: rtl/param_frame_receiver.sv
// Serial frame receiver: hunts a header, streams a fixed-length payload,
// deserialises it into word_out and counts completed frames.
// Ports: clk, rst (async, high), clk_en (sample strobe), ser_in, abort;
//        ser_out, ser_out_valid, bit_idx, word_out, word_valid,
//        frame_cnt, hunting.
module param_frame_receiver
    import frame_rx_pkg::*;
#(
    parameter int                   PATTERN_W   = 5,
    parameter logic [PATTERN_W-1:0] PATTERN     = 5'b11010,
    parameter int                   PAYLOAD_LEN = 10,
    parameter int                   FRAME_CNT_W = 8,
    localparam int                  CNT_W       = clog2Min1(PAYLOAD_LEN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_en,
    input  logic                   ser_in,
    input  logic                   abort,
    output logic                   ser_out,
    output logic                   ser_out_valid,
    output logic [CNT_W-1:0]       bit_idx,
    output logic [PAYLOAD_LEN-1:0] word_out,
    output logic                   word_valid,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   hunting
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAYLOAD_LEN - 1);

    state_t                   stateQ;
    state_t                   stateD;
    logic                     match;
    logic                     hmEn;
    logic                     hmClr;
    logic                     complete;
    logic                     shiftEn;
    logic                     lastBit;
    logic [PAYLOAD_LEN-1:0]   payloadNext;

    pattern_matcher #(
        .PATTERN_W (PATTERN_W),
        .PATTERN   (PATTERN)
    ) uMatcher (
        .clk    (clk),
        .rst    (rst),
        .en     (hmEn),
        .clr    (hmClr),
        .bit_in (ser_in),
        .match  (match)
    );

    assign lastBit = (bit_idx == LAST_IDX);

    always_comb begin
        stateD   = stateQ;
        hmEn     = 1'b0;
        hmClr    = 1'b0;
        complete = 1'b0;
        shiftEn  = 1'b0;
        if (clk_en) begin
            if (abort) begin
                // Abort wins over both a header hit and a completion.
                stateD = ST_HUNT;
                hmClr  = 1'b1;
            end else begin
                unique case (stateQ)
                    ST_HUNT: begin
                        hmEn = 1'b1;
                        if (match) begin
                            stateD = ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        shiftEn = 1'b1;
                        if (lastBit) begin
                            complete = 1'b1;
                            hmClr    = 1'b1;
                            stateD   = ST_HUNT;
                        end
                    end
                endcase
            end
        end
    end

    // The register keeps only PAYLOAD_LEN-1 bits; the newest bit
    // comes straight from ser_in when the word completes.
    if (PAYLOAD_LEN == 1) begin : gOneBit
        assign payloadNext = ser_in;
    end else begin : gShift
        logic [PAYLOAD_LEN-2:0] payloadSr;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                payloadSr <= '0;
            end else if (shiftEn) begin
                payloadSr <= payloadNext[PAYLOAD_LEN-2:0];
            end
        end

        assign payloadNext = {payloadSr, ser_in};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ     <= ST_HUNT;
            bit_idx    <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            stateQ     <= stateD;
            // Pulse clears on every edge, enabled or not.
            word_valid <= complete;
            if (clk_en) begin
                if (abort || complete) begin
                    bit_idx <= '0;
                end else if (shiftEn) begin
                    bit_idx <= bit_idx + 1'b1;
                end
                if (complete) begin
                    word_out  <= payloadNext;
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    assign ser_out       = ser_in;
    assign ser_out_valid = (stateQ == ST_PAYLOAD);
    assign hunting       = (stateQ == ST_HUNT);

endmodule

// File: tb/tb_param_frame_receiver.sv
// Directed bench for param_frame_receiver with a word scoreboard.
// Covers default and overridden parameter sets.
module tb_param_frame_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en;
    logic       ser_in;
    logic       abort;
    logic       serOut;
    logic       serOutValid;
    logic [3:0] bitIdx;
    logic [9:0] wordOut;
    logic       wordValid;
    logic [7:0] frameCnt;
    logic       hunting;

    logic       rstB;
    logic       serB;
    logic       abortB;
    logic       bSerOut;
    logic       bSov;
    logic [3:0] bBitIdx;
    logic [9:0] bWordOut;
    logic       bWordValid;
    logic [1:0] bFrameCnt;
    logic       bHunting;

    int passCnt = 0;
    int totalCnt = 0;
    int failCnt = 0;
    int gap = 0;
    int sovClks = 0;
    int wvPulses = 0;
    int expCnt = 0;
    int expCntB = 0;
    logic prevWv = 1'b0;
    logic prevWvB = 1'b0;

    logic [9:0] qWord[$];
    int         qCnt[$];
    logic [9:0] qWordB[$];
    int         qCntB[$];

    always #5 clk = ~clk;

    param_frame_receiver dutA (
        .clk           (clk),
        .rst           (rst),
        .clk_en        (clk_en),
        .ser_in        (ser_in),
        .abort         (abort),
        .ser_out       (serOut),
        .ser_out_valid (serOutValid),
        .bit_idx       (bitIdx),
        .word_out      (wordOut),
        .word_valid    (wordValid),
        .frame_cnt     (frameCnt),
        .hunting       (hunting)
    );

    param_frame_receiver #(
        .PATTERN_W   (3),
        .PATTERN     (3'b000),
        .FRAME_CNT_W (2)
    ) dutB (
        .clk           (clk),
        .rst           (rstB),
        .clk_en        (clk_en),
        .ser_in        (serB),
        .abort         (abortB),
        .ser_out       (bSerOut),
        .ser_out_valid (bSov),
        .bit_idx       (bBitIdx),
        .word_out      (bWordOut),
        .word_valid    (bWordValid),
        .frame_cnt     (bFrameCnt),
        .hunting       (bHunting)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (serOutValid) sovClks++;
        if (wordValid) begin
            wvPulses++;
            chk("wv_width", {31'd0, prevWv}, 0);
            chk("sbA_pending", {31'd0, qWord.size() != 0}, 1);
            if (qWord.size() != 0) begin
                chk("word_out", {22'd0, wordOut}, {22'd0, qWord.pop_front()});
                chk("frame_cnt", {24'd0, frameCnt}, qCnt.pop_front());
            end
        end
        prevWv = wordValid;
        if (bWordValid) begin
            chk("b_wv_width", {31'd0, prevWvB}, 0);
            chk("sbB_pending", {31'd0, qWordB.size() != 0}, 1);
            if (qWordB.size() != 0) begin
                chk("b_word_out", {22'd0, bWordOut}, {22'd0, qWordB.pop_front()});
                chk("b_frame_cnt", {30'd0, bFrameCnt}, qCntB.pop_front());
            end
        end
        prevWvB = bWordValid;
    endtask

    task automatic sendBit(input logic b, input logic ab);
        repeat (gap) begin
            clk_en = 1'b0;
            tick();
        end
        clk_en = 1'b1;
        ser_in = b;
        abort  = ab;
        tick();
        abort  = 1'b0;
    endtask

    task automatic sendHeader();
        logic [4:0] pat;
        pat = 5'b11010;
        for (int i = 4; i >= 0; i--) sendBit(pat[i], 1'b0);
    endtask

    task automatic sendPayload(input logic [9:0] w);
        expCnt = (expCnt + 1) % 256;
        qWord.push_back(w);
        qCnt.push_back(expCnt);
        for (int i = 9; i >= 0; i--) begin
            chk("bit_idx", {28'd0, bitIdx}, 9 - i);
            chk("sov_in_payload", {31'd0, serOutValid}, 1);
            sendBit(w[i], 1'b0);
        end
    endtask

    task automatic sendBitB(input logic b);
        clk_en = 1'b1;
        serB   = b;
        tick();
    endtask

    task automatic sendPayloadB(input logic [9:0] w);
        expCntB = (expCntB + 1) % 4;
        qWordB.push_back(w);
        qCntB.push_back(expCntB);
        for (int i = 9; i >= 0; i--) begin
            chk("b_bit_idx", {28'd0, bBitIdx}, 9 - i);
            sendBitB(w[i]);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        qWord.delete();
        qCnt.delete();
        expCnt = 0;
        prevWv = 1'b0;
    endtask

    initial begin
        logic [5:0] noise;
        logic [9:0] w;
        logic [9:0] pb [5];
        pb[0] = 10'h2A5;
        pb[1] = 10'h1FF;
        pb[2] = 10'h000;
        pb[3] = 10'h3C3;
        pb[4] = 10'h155;

        rst = 1'b1;
        rstB = 1'b1;
        clk_en = 1'b1;
        ser_in = 1'b0;
        abort = 1'b0;
        serB = 1'b0;
        abortB = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_hunting", {31'd0, hunting}, 1);
        chk("rst_sov", {31'd0, serOutValid}, 0);
        chk("rst_bit_idx", {28'd0, bitIdx}, 0);
        chk("rst_word_out", {22'd0, wordOut}, 0);
        chk("rst_word_valid", {31'd0, wordValid}, 0);
        chk("rst_frame_cnt", {24'd0, frameCnt}, 0);

        // Basic frame
        sovClks = 0;
        wvPulses = 0;
        sendHeader();
        chk("t1_hunt_off", {31'd0, hunting}, 0);
        sendPayload(10'b1011001110);
        chk("t1_sov_clks", sovClks, 10);
        chk("t1_wv_pulses", wvPulses, 1);
        chk("t1_hunting", {31'd0, hunting}, 1);
        chk("t1_frame_cnt", {24'd0, frameCnt}, 1);
        chk("t1_word", {22'd0, wordOut}, 10'b1011001110);

        // Leading noise, header-like payload
        doReset();
        noise = 6'b111010;
        for (int i = 5; i >= 1; i--) sendBit(noise[i], 1'b0);
        chk("t2_no_early", {31'd0, hunting}, 1);
        sendBit(noise[0], 1'b0);
        chk("t2_match6", {31'd0, hunting}, 0);
        sendPayload(10'b1101011010);
        chk("t2_frame_cnt", {24'd0, frameCnt}, 1);
        chk("t2_hunting", {31'd0, hunting}, 1);

        // Sparse clock enable
        doReset();
        gap = 2;
        sovClks = 0;
        wvPulses = 0;
        sendHeader();
        sendPayload(10'b1011001110);
        gap = 0;
        chk("t3_sov_clks", sovClks, 30);
        chk("t3_wv_pulses", wvPulses, 1);
        tick();
        chk("t3_wv_cleared", {31'd0, wordValid}, 0);
        chk("t3_word", {22'd0, wordOut}, 10'b1011001110);

        // Abort at bit_idx 4, then on the final bit
        w = 10'b0110100101;
        sendHeader();
        for (int i = 9; i >= 6; i--) sendBit(w[i], 1'b0);
        chk("t4_idx4", {28'd0, bitIdx}, 4);
        sendBit(w[5], 1'b1);
        chk("t4_hunting", {31'd0, hunting}, 1);
        chk("t4_bit_idx", {28'd0, bitIdx}, 0);
        chk("t4_word_hold", {22'd0, wordOut}, 10'b1011001110);
        chk("t4_cnt_hold", {24'd0, frameCnt}, 1);
        chk("t4_no_wv", {31'd0, wordValid}, 0);
        sendHeader();
        sendPayload(10'h2A5);
        chk("t4_next_cnt", {24'd0, frameCnt}, 2);
        sendHeader();
        for (int i = 9; i >= 1; i--) sendBit(w[i], 1'b0);
        chk("t4_idx9", {28'd0, bitIdx}, 9);
        sendBit(w[0], 1'b1);
        chk("t4_last_cnt", {24'd0, frameCnt}, 2);
        chk("t4_last_word", {22'd0, wordOut}, 10'h2A5);
        chk("t4_last_hunt", {31'd0, hunting}, 1);

        // Async reset mid-payload
        sendHeader();
        for (int i = 9; i >= 7; i--) sendBit(w[i], 1'b0);
        rst = 1'b1;
        #1;
        chk("t5_hunting", {31'd0, hunting}, 1);
        chk("t5_sov", {31'd0, serOutValid}, 0);
        chk("t5_bit_idx", {28'd0, bitIdx}, 0);
        chk("t5_word", {22'd0, wordOut}, 0);
        chk("t5_wv", {31'd0, wordValid}, 0);
        chk("t5_cnt", {24'd0, frameCnt}, 0);
        #1;
        rst = 1'b0;
        qWord.delete();
        qCnt.delete();
        expCnt = 0;
        sendHeader();
        sendPayload(10'h3C3);
        chk("t5_frame_cnt", {24'd0, frameCnt}, 1);

        // Overridden parameters on the second instance
        ser_in = 1'b0;
        rstB = 1'b0;
        sendBitB(1'b0);
        chk("t6_zero1", {31'd0, bHunting}, 1);
        sendBitB(1'b0);
        chk("t6_zero2", {31'd0, bHunting}, 1);
        sendBitB(1'b0);
        chk("t6_zero3", {31'd0, bHunting}, 0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                for (int j = 0; j < 3; j++) sendBitB(1'b0);
            end
            sendPayloadB(pb[k]);
            chk("t6_cnt_seq", {30'd0, bFrameCnt}, (k + 1) % 4);
        end

        chk("sbA_drained", qWord.size(), 0);
        chk("sbB_drained", qWordB.size(), 0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/param_frame_receiver.md
Name: param_frame_receiver

Overview:
Serial frame receiver. It hunts a bit stream for a parametrised header pattern, then passes through a fixed-length payload with a valid flag and a bit index. It also deserialises the payload into a parallel word and counts received frames. It sits between the serial input pin logic and downstream word-level consumers, and is gated by the shared clock-enable strobe.

Parameters:
PATTERN_W, 5, header length in bits (>=1).
PATTERN, 5'b11010, header value; MSB is the first bit received.
PAYLOAD_LEN, 10, payload bits per frame (>=1).
FRAME_CNT_W, 8, width of the frame counter.
CNT_W, derived as max(1, $clog2(PAYLOAD_LEN)), width of the bit index (localparam).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
clk_en  in  1  sample strobe; all state advances only on edges where clk_en=1.
ser_in  in  1  serial data.
abort  in  1  synchronous; when high on an enabled edge, the current frame is dropped.
ser_out  out  1  combinational pass-through of ser_in.
ser_out_valid  out  1  high while state=PAYLOAD (decoded from the registered state).
bit_idx  out  CNT_W  index of the current payload bit, 0..PAYLOAD_LEN-1; 0 in HUNT.
word_out  out  PAYLOAD_LEN  last completed payload, first bit received in the MSB; holds until the next completion.
word_valid  out  1  one-clk pulse when word_out updates.
frame_cnt  out  FRAME_CNT_W  count of completed frames; wraps modulo 2^FRAME_CNT_W.
hunting  out  1  high while state=HUNT.

Behaviour:
- Reset (async): state=HUNT, hist=0, fill=0, bit_idx=0, word_out=0, word_valid=0, frame_cnt=0. Resulting outputs: hunting=1, ser_out_valid=0. A reset mid-frame discards the partial payload.
- Edges with clk_en=0: all registers hold, except word_valid, which is cleared on every clk edge.
- HUNT state:
  - Each enabled edge shifts ser_in into hist (PATTERN_W-1 bits) and increments fill, saturating at PATTERN_W-1.
  - match = ({hist, ser_in} == PATTERN) && (fill == PATTERN_W-1). The fill condition prevents false matches against the reset value of hist.
  - On an enabled edge with match=1 and abort=0: state goes to PAYLOAD and bit_idx=0. The header bit itself is not payload.
  - For PATTERN_W=1, hist is empty and match = (ser_in == PATTERN).
- PAYLOAD state:
  - Each enabled edge shifts ser_in into the payload shift register and increments bit_idx.
  - On the enabled edge where bit_idx == PAYLOAD_LEN-1:
    - word_out is loaded with the complete payload including that bit.
    - word_valid=1 for the next clk cycle.
    - frame_cnt increments.
    - state returns to HUNT with bit_idx=0, hist=0, fill=0.
  - Headers are never detected inside a payload. A new header requires PATTERN_W fresh bits after the payload ends.
- Latency: ser_out_valid rises on the edge after the last header bit and stays high for exactly PAYLOAD_LEN enabled sample periods. word_valid rises on the edge after the last payload bit.
- abort on an enabled edge, any state:
  - state goes to HUNT; hist, fill and bit_idx are cleared.
  - word_out, frame_cnt and word_valid are unchanged. No completion occurs, even on the final payload bit.
  - abort has priority over match and over completion.
- State encoding: HUNT=1'b0, PAYLOAD=1'b1. No illegal states exist.

Decomposition:
- Shared package frame_rx_pkg: the state encoding constants (ST_HUNT, ST_PAYLOAD) and a function returning clog2 with a floor of 1.
- One sub-module, pattern_matcher:
  - Contains the hist shift register, the fill counter and the comparator.
  - Parameters PATTERN_W and PATTERN.
  - Ports clk, rst, en, clr, bit_in, match.
  - The top drives clr on frame completion and on abort.
  - The top module holds the state register, the payload shift register, bit_idx and frame_cnt.

Test Plan:
1. Defaults, clk_en=1, send 1,1,0,1,0 then 1,0,1,1,0,0,1,1,1,0 -> ser_out_valid high for exactly 10 cycles, bit_idx 0..9, word_out=10'b1011001110, one word_valid pulse, frame_cnt=1, hunting=1 afterwards.
2. Leading noise 1,1,1,0,1,0 -> match on the 6th bit, payload starts on the next bit. A payload containing 11010 produces no restart and completes normally, with frame_cnt=1.
3. clk_en high only every 3rd clk, same stream as test 1 -> identical word_out. ser_out_valid spans 30 clks; word_valid is exactly 1 clk wide.
4. abort asserted at bit_idx=4 -> hunting=1 next edge. word_out and frame_cnt unchanged, no word_valid. The next complete frame is received correctly.
5. rst asserted asynchronously mid-payload -> all outputs return to reset values immediately. The following frame decodes with frame_cnt=1.
6. Override PATTERN_W=3, PATTERN=3'b000, FRAME_CNT_W=2 -> no match before three zeros after reset. Five back-to-back frames give a frame_cnt sequence of 1,2,3,0,1.
